// File: rtl/fpdlink_pkg.sv
// Shared types and lane packing for the FPD-Link pattern generator.
// Define FPDLINK_JEIDA_EN for JEIDA bit mapping; default build packs VESA.
package fpdlink_pkg;
  typedef enum logic [1:0] {PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_MOVE} pat_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam logic [6:0] CK_WORD   = 7'b1100011;
  localparam rgb888_t    RGB_WHITE = rgb888_t'(24'hFFFFFF);

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam rgb888_t BAR_LUT [8] = '{
    rgb888_t'(24'hFFFFFF), rgb888_t'(24'hFFFF00), rgb888_t'(24'h00FFFF), rgb888_t'(24'h00FF00),
    rgb888_t'(24'hFF00FF), rgb888_t'(24'hFF0000), rgb888_t'(24'h0000FF), rgb888_t'(24'h000000)
  };

  // Returns {L3,L2,L1,L0}; bit 0 of each lane is D0.
  function automatic logic [27:0] pack_lanes(rgb888_t c, logic de, logic vs, logic hs);
    logic [6:0] l0, l1, l2, l3;
`ifdef FPDLINK_JEIDA_EN
    l0 = {c.g[2], c.r[7:2]};
    l1 = {c.b[3:2], c.g[7:3]};
    l2 = {de, vs, hs, c.b[7:4]};
    l3 = {1'b0, c.b[1:0], c.g[1:0], c.r[1:0]};
`else
    l0 = {c.g[0], c.r[5:0]};
    l1 = {c.b[1:0], c.g[5:1]};
    l2 = {de, vs, hs, c.b[5:2]};
    l3 = {1'b0, c.b[7:6], c.g[7:6], c.r[7:6]};
`endif
    return {l3, l2, l1, l0};
  endfunction
endpackage

// File: rtl/fpdlink_timing.sv
// Video timing: h/v/frame counters and combinational HS/VS/DE/sof decode.
// Counters hold at zero while en_i is low; decoded flags are blanked then.
module fpdlink_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 21,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic [9:0] h_cnt_lo,
  output logic       v_cnt_b3,
  output logic [6:0] frame_lo,
  output logic       h_last,
  output logic       de,
  output logic       hs,
  output logic       vs,
  output logic       sof
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Pattern logic taps h[9:2] and v[3], so keep at least that many bits.
  localparam int HW = ($clog2(H_TOTAL + 1) < 10) ? 10 : $clog2(H_TOTAL + 1);
  localparam int VW = ($clog2(V_TOTAL + 1) < 4)  ? 4  : $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_END  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_END  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [7:0]    frame_cnt;
  logic          v_last;

  assign h_last = (h_cnt == H_END);
  assign v_last = (v_cnt == V_END);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (!en_i) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      if (v_last) begin
        v_cnt     <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        v_cnt <= v_cnt + VW'(1);
      end
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  assign de  = en_i && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs  = (en_i && h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_POL : !SYNC_POL;
  assign vs  = (en_i && v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_POL : !SYNC_POL;
  assign sof = en_i && (h_cnt == '0) && (v_cnt == '0);

  assign h_cnt_lo = h_cnt[9:0];
  assign v_cnt_b3 = v_cnt[3];
  assign frame_lo = frame_cnt[6:0];
endmodule

// File: rtl/fpdlink_pattern_gen.sv
// PCLK-domain test-pattern source feeding four OVIDEO 7:1 data lanes plus clock lane.
// Lane mapping is VESA unless FPDLINK_JEIDA_EN is defined (see fpdlink_pkg).
module fpdlink_pattern_gen
  import fpdlink_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 21,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [1:0]  pat_i,
  output logic [27:0] q_o,
  output logic [6:0]  ck_o,
  output logic        sof_o
);
  localparam int   BAR_W   = H_ACTIVE / 8;
  localparam int   BW      = $clog2(BAR_W + 1);
  localparam logic SYNC_IDLE = !SYNC_POL;

  logic [9:0] h_cnt_lo;
  logic       v_cnt_b3;
  logic [6:0] frame_lo;
  logic       h_last, de_c, hs_c, vs_c, sof_c;

  fpdlink_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .h_cnt_lo(h_cnt_lo), .v_cnt_b3(v_cnt_b3), .frame_lo(frame_lo),
    .h_last(h_last), .de(de_c), .hs(hs_c), .vs(vs_c), .sof(sof_c)
  );

  pat_e     pat_q, pat_eff;
  logic [BW-1:0] bar_pos;
  logic [2:0]    bar_idx;
  rgb888_t  rgb_c, rgb1;
  logic     de1, hs1, vs1, sof1;
  logic     unused_bits;

  assign unused_bits = ^h_cnt_lo[1:0];

  // The first pixel of a frame already uses the newly sampled selection.
  assign pat_eff = sof_c ? pat_e'(pat_i) : pat_q;

  always_comb begin
    rgb_c = '0;
    case (pat_eff)
      PAT_BARS:  rgb_c = BAR_LUT[bar_idx];
      PAT_RAMP:  rgb_c = rgb888_t'({3{h_cnt_lo[9:2]}});
      PAT_CHECK: if (h_cnt_lo[3] ^ v_cnt_b3) rgb_c = RGB_WHITE;
      PAT_MOVE:  if (h_cnt_lo[9:3] == frame_lo) rgb_c = RGB_WHITE;
      default:   rgb_c = '0;
    endcase
    if (!de_c) rgb_c = '0;
  end

  // Bar index tracks h_cnt by counting bar widths, avoiding a divider.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pat_q   <= PAT_BARS;
      bar_pos <= '0;
      bar_idx <= '0;
    end else begin
      if (sof_c) pat_q <= pat_e'(pat_i);
      if (!en_i || h_last) begin
        bar_pos <= '0;
        bar_idx <= '0;
      end else if (bar_pos == BW'(BAR_W - 1)) begin
        bar_pos <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pos <= bar_pos + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rgb1  <= '0;
      de1   <= 1'b0;
      hs1   <= SYNC_IDLE;
      vs1   <= SYNC_IDLE;
      sof1  <= 1'b0;
      q_o   <= pack_lanes('0, 1'b0, SYNC_IDLE, SYNC_IDLE);
      sof_o <= 1'b0;
    end else begin
      rgb1  <= rgb_c;
      de1   <= de_c;
      hs1   <= hs_c;
      vs1   <= vs_c;
      sof1  <= sof_c;
      q_o   <= pack_lanes(rgb1, de1, vs1, hs1);
      sof_o <= sof1;
    end
  end

  assign ck_o = CK_WORD;
endmodule

// File: tb/tb_fpdlink_pattern_gen.sv
// Randomized scoreboard bench for fpdlink_pattern_gen on a reduced raster.
module tb_fpdlink_pattern_gen;
  localparam int HA = 160, HF = 16, HSY = 24, HB = 40;
  localparam int VA = 12, VF = 1, VSY = 3, VB = 4;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;
  localparam int BARW = HA / 8;
  localparam logic [6:0] CKW = 7'b1100011;
  localparam logic [27:0] BLANK_Q = {7'h00, 7'h30, 7'h00, 7'h00};
  localparam logic [27:0] WHITE_Q = {7'h3F, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [27:0] YELLOW_Q = {7'h0F, 7'h70, 7'h1F, 7'h7F};
`ifdef FPDLINK_JEIDA_EN
  localparam logic [27:0] GREY1_Q = {7'h15, 7'h70, 7'h00, 7'h00};
`else
  localparam logic [27:0] GREY1_Q = {7'h00, 7'h70, 7'h20, 7'h41};
`endif

  logic        clk = 1'b0;
  logic        rst_i, en_i;
  logic [1:0]  pat_i;
  logic [27:0] q_o;
  logic [6:0]  ck_o;
  logic        sof_o;

  always #5 clk = ~clk;

  fpdlink_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pat_i(pat_i),
    .q_o(q_o), .ck_o(ck_o), .sof_o(sof_o)
  );

  typedef struct {
    logic [27:0] q;
    logic        sof;
    bit          en;
    int          x, y, pat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  bit   mon_on = 1'b0;
  int   t = 0, pat_frame = 0;

  function automatic logic [27:0] ref_pack(logic [23:0] c, bit de, bit vs, bit hs);
    logic [7:0] r, g, b;
    r = c[23:16]; g = c[15:8]; b = c[7:0];
`ifdef FPDLINK_JEIDA_EN
    return {1'b0, b[1], b[0], g[1], g[0], r[1], r[0],
            de, vs, hs, b[7], b[6], b[5], b[4],
            b[3], b[2], g[7], g[6], g[5], g[4], g[3],
            g[2], r[7], r[6], r[5], r[4], r[3], r[2]};
`else
    return {1'b0, b[7], b[6], g[7], g[6], r[7], r[6],
            de, vs, hs, b[5], b[4], b[3], b[2],
            b[1], b[0], g[5], g[4], g[3], g[2], g[1],
            g[0], r[5], r[4], r[3], r[2], r[1], r[0]};
`endif
  endfunction

  function automatic logic [23:0] ref_rgb(int x, int y, int fr, int pat);
    int grey;
    if (!(x < HA && y < VA)) return 24'h0;
    case (pat)
      0: case (x / BARW)
           0: return 24'hFFFFFF;  1: return 24'hFFFF00;
           2: return 24'h00FFFF;  3: return 24'h00FF00;
           4: return 24'hFF00FF;  5: return 24'hFF0000;
           6: return 24'h0000FF;  default: return 24'h000000;
         endcase
      1: begin grey = (x / 4) % 256; return {grey[7:0], grey[7:0], grey[7:0]}; end
      2: return (((x / 8) + (y / 8)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
      default: return (((x / 8) % 128) == (fr % 128)) ? 24'hFFFFFF : 24'h0;
    endcase
  endfunction

  function automatic exp_t blank_exp();
    exp_t e;
    e.q = BLANK_Q; e.sof = 1'b0; e.en = 1'b0; e.x = 0; e.y = 0; e.pat = 0;
    return e;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, push the response they should produce, move to next negedge.
  task automatic step(bit en, int pat);
    exp_t e;
    int x, y, fr;
    bit de, hs, vs;
    en_i = en;
    pat_i = pat[1:0];
    e = blank_exp();
    if (en) begin
      x = t % HT; y = (t / HT) % VT; fr = (t / FT) % 256;
      if (x == 0 && y == 0) pat_frame = pat;
      de = (x < HA) && (y < VA);
      hs = !(x >= HA + HF && x < HA + HF + HSY);
      vs = !(y >= VA + VF && y < VA + VF + VSY);
      e.q = ref_pack(ref_rgb(x, y, fr, pat_frame), de, vs, hs);
      e.sof = (x == 0 && y == 0);
      e.en = 1'b1; e.x = x; e.y = y; e.pat = pat_frame;
      t++;
    end else begin
      t = 0;
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    if (mon_on) begin
      #1;
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_underflow: got empty queue, required an entry");
      end else begin
        e = sb.pop_front();
        check("lanes_sof_ck", {q_o, sof_o, ck_o}, {e.q, e.sof, CKW});
        if (e.en && e.pat == 0 && e.y == 0 && e.x == 0)
          check("bar0_white", q_o, WHITE_Q);
        if (e.en && e.pat == 0 && e.y == 0 && e.x == BARW + 5)
          check("bar1_yellow", q_o, YELLOW_Q);
        if (e.en && e.pat == 1 && e.y == 1 && e.x == 4)
          check("grey01", q_o, GREY1_Q);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    int p, mid, drop, gap;
    int plan[5] = '{2, 1, 3, 0, 2};
    rst_i = 1'b1; en_i = 1'b0; pat_i = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_q", q_o, BLANK_Q);
    check("rst_sof", sof_o, 1'b0);
    check("rst_ck", ck_o, CKW);
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_q", q_o, BLANK_Q);

    sb.push_back(blank_exp());
    mon_on = 1'b1;
    repeat (10) step(1'b0, $urandom_range(0, 3));

    // Frame patterns 0,2,1,3,0; early glitches and the mid-frame update must not bite until next frame.
    p = 0;
    for (int f = 0; f < 5; f++) begin
      mid = FT / 2 + $urandom_range(0, HT);
      for (int c = 0; c < FT; c++) begin
        if (c > 0 && c < FT / 2 && $urandom_range(0, 299) == 0) p = $urandom_range(0, 3);
        if (c == mid) p = plan[f];
        step(1'b1, p);
      end
    end

    // Enable dropped mid-frame, then restarted.
    drop = 15 * HT + $urandom_range(0, HT - 1);
    for (int c = 0; c < drop; c++) step(1'b1, p);
    gap = $urandom_range(1, 20);
    for (int c = 0; c < gap; c++) step(1'b0, $urandom_range(0, 3));
    p = $urandom_range(0, 3);
    for (int c = 0; c < FT + 100; c++) step(1'b1, p);

    // Asynchronous reset during active video.
    for (int c = 0; c < 5 * HT + 50 - 100; c++) step(1'b1, p);
    mon_on = 1'b0;
    rst_i = 1'b1;
    #1;
    check("async_rst_q", q_o, BLANK_Q);
    check("async_rst_sof", sof_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    sb.delete();
    t = 0;
    sb.push_back(blank_exp());
    mon_on = 1'b1;
    p = $urandom_range(0, 3);
    for (int c = 0; c < FT + 50; c++) step(1'b1, p);
    repeat (4) step(1'b0, 0);
    mon_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
